// File: rtl/demux1to4by32_reg_if.sv
// Handshake bus for the registered 1-to-4 demultiplexer: one tagged input stream,
// four holding-register output channels and the accepted-transfer counter.
interface demux1to4by32_reg_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNTW  = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       address;
  logic [WIDTH-1:0] in_data;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] output0;
  logic [WIDTH-1:0] output1;
  logic [WIDTH-1:0] output2;
  logic [WIDTH-1:0] output3;
  logic [CNTW-1:0]  xfer_count;

  modport master (
    output in_valid, address, in_data, out_ready,
    input  in_ready, out_valid, output0, output1, output2, output3, xfer_count
  );

  modport slave (
    input  in_valid, address, in_data, out_ready,
    output in_ready, out_valid, output0, output1, output2, output3, xfer_count
  );
endinterface

// File: rtl/demux1to4by32_reg.sv
// Registered 1-to-4 demultiplexer: each destination owns a one-entry holding register,
// so a stalled consumer only blocks words addressed to it.
module demux1to4by32_reg #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNTW  = 16
) (
  input logic               clk,
  input logic               reset,
  demux1to4by32_reg_if.slave bus
);

  logic [3:0]       v_q;
  logic [WIDTH-1:0] d_q [4];
  logic [CNTW-1:0]  cnt_q;
  logic             accept;
  logic [3:0]       pop;

  // Readiness looks only at the addressed channel; a pop frees it for a same-cycle refill.
  always_comb begin
    bus.in_ready = !v_q[bus.address] | bus.out_ready[bus.address];
    accept       = bus.in_valid & bus.in_ready;
    pop          = v_q & bus.out_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q   <= '0;
      cnt_q <= '0;
      for (int unsigned k = 0; k < 4; k++) begin
        d_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (accept && (bus.address == 2'(k))) begin
          d_q[k] <= bus.in_data;
          v_q[k] <= 1'b1;
        end else if (pop[k]) begin
          v_q[k] <= 1'b0;
        end
      end
      if (accept) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.out_valid  = v_q;
  assign bus.output0    = d_q[0];
  assign bus.output1    = d_q[1];
  assign bus.output2    = d_q[2];
  assign bus.output3    = d_q[3];
  assign bus.xfer_count = cnt_q;

endmodule

// File: tb/tb_demux1to4by32_reg.sv
// Self-checking bench: directed vector table, hand-written stall/reset sequences and
// randomized traffic, all compared against a queue-per-channel reference model.
module tb_demux1to4by32_reg;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  demux1to4by32_reg_if #(.WIDTH(32), .CNTW(16)) bus ();
  demux1to4by32_reg_if #(.WIDTH(32), .CNTW(4))  bus2 ();

  demux1to4by32_reg #(.WIDTH(32), .CNTW(16)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  demux1to4by32_reg #(.WIDTH(32), .CNTW(4)) dut_small (
    .clk   (clk),
    .reset (rst),
    .bus   (bus2)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: each channel is a queue of at most one pending word.
  logic [31:0] mq [4][$];
  logic [31:0] mlast [4];
  logic [15:0] mcnt;
  logic        last_ready;

  typedef struct {
    logic        iv;
    logic [1:0]  a;
    logic [31:0] d;
    logic [3:0]  rdy;
    logic        er;
    logic [3:0]  ev;
    int          ch;
    logic [31:0] ed;
    logic [15:0] ec;
  } vec_t;
  vec_t tbl [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] outk(input int k);
    case (k)
      0:       return bus.output0;
      1:       return bus.output1;
      2:       return bus.output2;
      default: return bus.output3;
    endcase
  endfunction

  task automatic drive(input logic iv, input logic [1:0] a, input logic [31:0] d,
                       input logic [3:0] rdy);
    bus.in_valid  = iv;
    bus.address   = a;
    bus.in_data   = d;
    bus.out_ready = rdy;
  endtask

  // Advance one clock with the current inputs, updating and checking the model.
  task automatic tick();
    bit mr;
    bit acc;
    int a;
    #1;
    a  = int'(bus.address);
    mr = (mq[a].size() == 0) || bus.out_ready[a];
    last_ready = bus.in_ready;
    check("in_ready_model", {31'd0, bus.in_ready}, {31'd0, mr});
    acc = bus.in_valid && mr;
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        mq[k].delete();
        mlast[k] = '0;
      end
      mcnt = '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (bus.out_ready[k] && mq[k].size() > 0) void'(mq[k].pop_front());
      end
      if (acc) begin
        mq[a].push_back(bus.in_data);
        mlast[a] = bus.in_data;
        mcnt++;
      end
    end
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("out_valid%0d_model", k), {31'd0, bus.out_valid[k]},
            {31'd0, mq[k].size() > 0});
      check($sformatf("output%0d_model", k), outk(k), mlast[k]);
    end
    check("xfer_count_model", {16'd0, bus.xfer_count}, {16'd0, mcnt});
  endtask

  initial begin
    drive(1'b0, 2'd0, '0, 4'h0);
    bus2.in_valid  = 1'b0;
    bus2.address   = 2'd0;
    bus2.in_data   = '0;
    bus2.out_ready = 4'h0;
    for (int k = 0; k < 4; k++) mlast[k] = '0;
    mcnt = '0;

    // Reset state
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 2'd0, '0, 4'h0);
    #1;
    check("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("reset_out_valid", {28'd0, bus.out_valid}, 32'd0);
    check("reset_output0", bus.output0, 32'd0);
    check("reset_xfer_count", {16'd0, bus.xfer_count}, 32'd0);

    // Directed vectors: single delivery, pop, pop/refill, streaming
    tbl.push_back('{1'b1, 2'd2, 32'h3F800000, 4'h0, 1'b1, 4'b0100, 2, 32'h3F800000, 16'd1});
    tbl.push_back('{1'b0, 2'd2, 32'h0,        4'h4, 1'b1, 4'b0000, 2, 32'h3F800000, 16'd1});
    tbl.push_back('{1'b1, 2'd0, 32'h1,        4'h0, 1'b1, 4'b0001, 0, 32'h1,        16'd2});
    tbl.push_back('{1'b1, 2'd0, 32'h2,        4'h1, 1'b1, 4'b0001, 0, 32'h2,        16'd3});
    tbl.push_back('{1'b0, 2'd0, 32'h0,        4'h1, 1'b1, 4'b0000, 0, 32'h2,        16'd3});
    for (int i = 0; i < 8; i++) begin
      tbl.push_back('{1'b1, 2'(i % 4), 32'(i + 1), 4'hF, 1'b1, 4'(1 << (i % 4)), i % 4,
                      32'(i + 1), 16'(4 + i)});
    end
    tbl.push_back('{1'b0, 2'd0, 32'h0, 4'hF, 1'b1, 4'b0000, 3, 32'h8, 16'd11});

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].iv, tbl[i].a, tbl[i].d, tbl[i].rdy);
      tick();
      check($sformatf("vec%0d_in_ready", i), {31'd0, last_ready}, {31'd0, tbl[i].er});
      check($sformatf("vec%0d_out_valid", i), {28'd0, bus.out_valid}, {28'd0, tbl[i].ev});
      check($sformatf("vec%0d_data", i), outk(tbl[i].ch), tbl[i].ed);
      check($sformatf("vec%0d_xfer_count", i), {16'd0, bus.xfer_count}, {16'd0, tbl[i].ec});
    end

    // Stall on channel 1 must not block channel 3
    drive(1'b1, 2'd1, 32'hDEADBEEF, 4'h0);
    tick();
    drive(1'b1, 2'd1, 32'h12345678, 4'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_in_ready", {31'd0, last_ready}, 32'd0);
      check("stall_output1", bus.output1, 32'hDEADBEEF);
      check("stall_out_valid", {28'd0, bus.out_valid}, 32'h2);
      check("stall_xfer_count", {16'd0, bus.xfer_count}, 32'd12);
    end
    drive(1'b1, 2'd3, 32'h12345678, 4'h0);
    tick();
    check("bypass_in_ready", {31'd0, last_ready}, 32'd1);
    check("bypass_output3", bus.output3, 32'h12345678);
    check("bypass_out_valid", {28'd0, bus.out_valid}, 32'hA);
    drive(1'b0, 2'd0, '0, 4'hF);
    tick();

    // Reset mid-operation drops the word presented during reset
    drive(1'b1, 2'd0, 32'hAAAA, 4'h0);
    tick();
    drive(1'b1, 2'd3, 32'hBBBB, 4'h0);
    tick();
    check("pre_reset_out_valid", {28'd0, bus.out_valid}, 32'h9);
    rst = 1'b1;
    drive(1'b1, 2'd1, 32'hCCCC, 4'h0);
    tick();
    rst = 1'b0;
    check("midreset_out_valid", {28'd0, bus.out_valid}, 32'd0);
    check("midreset_output0", bus.output0, 32'd0);
    check("midreset_output3", bus.output3, 32'd0);
    check("midreset_xfer_count", {16'd0, bus.xfer_count}, 32'd0);
    drive(1'b0, 2'd1, '0, 4'h0);
    tick();
    check("post_reset_out_valid", {28'd0, bus.out_valid}, 32'd0);
    check("post_reset_output1", bus.output1, 32'd0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom,
            4'($urandom_range(0, 15)));
      tick();
    end
    rst = 1'b0;

    // Counter wrap on a 4-bit counter instance
    rst = 1'b1;
    drive(1'b0, 2'd0, '0, 4'hF);
    tick();
    rst = 1'b0;
    check("wrap_reset_count", {28'd0, bus2.xfer_count}, 32'd0);
    bus2.out_ready = 4'hF;
    bus2.in_valid  = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus2.address = 2'(i % 4);
      bus2.in_data = 32'(i);
      tick();
      if (i == 15) check("wrap_count_16", {28'd0, bus2.xfer_count}, 32'd0);
    end
    bus2.in_valid = 1'b0;
    tick();
    check("wrap_count_17", {28'd0, bus2.xfer_count}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
